// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 receive checker: a per-bit recurrence check, a
// lock FSM and a saturating bit-error counter for BER measurement.
module prbs7_checker #(
  parameter int WORDWIDTH    = 16,
  parameter int ERRCNTWIDTH  = 16,
  parameter int LOCK_WORDS   = 4,
  parameter int UNLOCK_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   din_valid,
  input  logic [WORDWIDTH-1:0]   din,
  input  logic                   clear_cnt,
  output logic                   locked,
  output logic                   err_flag,
  output logic [WORDWIDTH-1:0]   err_bits,
  output logic [ERRCNTWIDTH-1:0] err_cnt
);
  localparam int W   = WORDWIDTH;
  localparam int PW  = $clog2(W + 1);
  localparam int SW  = ((ERRCNTWIDTH > PW) ? ERRCNTWIDTH : PW) + 1;
  localparam int GCW = $clog2(LOCK_WORDS + 1);
  localparam int BCW = $clog2(UNLOCK_WORDS + 1);
  localparam logic [SW-1:0] SAT = (SW'(1) << ERRCNTWIDTH) - SW'(1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [GCW-1:0] good_cnt, good_nxt;
  logic [BCW-1:0] bad_cnt, bad_nxt;
  logic [6:0]     hist;
  logic           hist_valid;

  logic [W+6:0]   x;
  logic [W-1:0]   e;
  logic [PW-1:0]  pop;
  logic [SW-1:0]  sum;
  logic           check, zero_word, word_bad;

  // hist[6] is the newest bit, so x is the bit stream in time order.
  assign x = {din, hist};

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_chk
      assign e[i] = x[i+7] ^ x[i+1] ^ x[i];
    end
  endgenerate

  assign check     = din_valid && hist_valid;
  // An all-zero stream satisfies the recurrence; a stuck-at-0 link must not lock.
  assign zero_word = (din == '0) && (hist == '0);
  assign word_bad  = (|e) || zero_word;

  always_comb begin
    pop = '0;
    for (int k = 0; k < W; k++) pop = pop + PW'(e[k]);
  end

  assign sum = SW'(err_cnt) + SW'(pop);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HUNT;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  // FSM next state, only advanced by checked words
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    if (check) begin
      case (state)
        HUNT: begin
          if (word_bad) begin
            good_nxt = '0;
          end else if (good_cnt == GCW'(LOCK_WORDS - 1)) begin
            good_nxt  = '0;
            state_nxt = LOCKED;
          end else begin
            good_nxt = good_cnt + GCW'(1);
          end
        end
        LOCKED: begin
          if (!word_bad) begin
            bad_nxt = '0;
          end else if (bad_cnt == BCW'(UNLOCK_WORDS - 1)) begin
            bad_nxt   = '0;
            state_nxt = HUNT;
          end else begin
            bad_nxt = bad_cnt + BCW'(1);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist       <= '0;
      hist_valid <= 1'b0;
      err_bits   <= '0;
      err_flag   <= 1'b0;
    end else if (din_valid) begin
      hist       <= din[W-1 -: 7];
      hist_valid <= 1'b1;
      if (hist_valid) begin
        err_bits <= e;
        err_flag <= |e;
      end
    end
  end

  // Counted against the pre-edge state: the lock-entry word is excluded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt <= '0;
    else if (clear_cnt)
      err_cnt <= '0;
    else if (check && state == LOCKED)
      err_cnt <= (sum > SAT) ? SAT[ERRCNTWIDTH-1:0] : sum[ERRCNTWIDTH-1:0];
  end
endmodule
